ddr_20g_adc_chk_ctrl: RTL and testbench
=======================================

Name: ddr_20g_adc_chk_ctrl

Overview:
- Session controller for the 20G ADC pattern checker (cfg_rst / adc_vld / adc_data / suc_cnt / err_cnt interface).
- Sequence per session: clear the checker, align to the pattern origin (lane0 == 0), gate a window of cfg_len beats into the checker, drain, then latch the result counters and a pass flag.
- Sits between the DDR readback stream and the checker. Software drives it through start/stop pulses and reads the status registers.

Parameters:
- DATA_WD, 256, width of the ADC beat; 16 lanes of 16 bits.
- CLR_CYC, 4, cycles chk_rst is held high at session start; range 1..15.
- DRAIN_CYC, 4, cycles waited after the last gated beat before the counters are latched; range 1..15.
- SYNC_TMO, 65535, maximum idle cycles in SYNC or RUN before the timeout abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; starts a session; ignored unless state is IDLE or DONE.
- stop  in  1  one-cycle pulse; ends RUN early (goes to DRAIN); ignored in other states.
- cfg_len  in  32  beats per window, sampled at start; 0 = unbounded, run until stop.
- adc_vld  in  1  upstream beat valid.
- adc_data  in  DATA_WD  upstream beat.
- chk_rst  out  1  drives checker cfg_rst.
- chk_vld  out  1  gated valid to the checker.
- chk_data  out  DATA_WD  registered copy of adc_data.
- suc_cnt  in  32  checker success count.
- err_cnt  in  32  checker error count.
- busy  out  1  high in CLR, SYNC, RUN, DRAIN.
- done  out  1  one-cycle pulse on entry to DONE.
- pass  out  1  result flag, valid in DONE.
- tmo  out  1  session aborted by timeout, valid in DONE.
- beat_cnt  out  32  beats gated in the last or current session.
- suc_lat  out  32  latched suc_cnt.
- err_lat  out  32  latched err_cnt.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Datapath latency:
  - chk_data <= adc_data every cycle (1-cycle latency).
  - chk_vld <= adc_vld & gate, where gate is the combinational "accept this beat" decision.
- IDLE / DONE:
  - On start: clear beat_cnt, suc_lat, err_lat, pass, tmo; latch cfg_len; go to CLR.
- CLR:
  - chk_rst = 1 for exactly CLR_CYC cycles, then go to SYNC.
- SYNC:
  - gate = adc_vld & (adc_data[15:0] == 16'h0).
  - The first such beat is forwarded, counted in beat_cnt, and moves the state to RUN.
  - If cfg_len == 1, go directly to DRAIN instead.
  - Non-matching beats are dropped.
- RUN:
  - gate = adc_vld. Each gated beat increments beat_cnt.
  - When beat_cnt reaches cfg_len on a gated beat (cfg_len != 0), that beat is forwarded and the state goes to DRAIN.
  - stop: go to DRAIN. If stop coincides with a beat, that beat is still forwarded.
- Timeout:
  - Idle counter resets on every adc_vld and on every state entry.
  - In SYNC or RUN, when it reaches SYNC_TMO: set tmo = 1 and go to DRAIN.
- DRAIN:
  - gate = 0. Wait DRAIN_CYC cycles.
  - Latch suc_lat = suc_cnt and err_lat = err_cnt.
  - pass = (err_cnt == 0) & (suc_cnt == beat_cnt) & (beat_cnt != 0) & ~tmo.
  - Go to DONE and pulse done.
- Priority:
  - start has no effect while busy.
  - In RUN, a length-reached beat together with stop yields a single DRAIN entry.
- beat_cnt saturates at 32'hFFFF_FFFF in unbounded mode.
- Async rst mid-session: returns to IDLE and clears all outputs. chk_rst drops to 0, and the next session re-clears the checker.

Optional Feature:
- Macro: ADC_CHK_STOP_ON_ERR_EN.
- Defined: in RUN, if err_cnt != 0 (sampled each cycle), gating stops immediately and the state goes to DRAIN; pass = 0 by definition.
- Undefined: errors do not affect sequencing; only length, stop or timeout end RUN.

Test Plan:
- Clean session: cfg_len = 8, pattern beats starting at lane0 = 0 every cycle.
  - Required: chk_rst high 4 cycles, 8 chk_vld pulses, beat_cnt = 8, suc_lat = 8, err_lat = 0, pass = 1, one done pulse.
- Sync alignment: 3 beats with lane0 = 0x0010 precede the origin; cfg_len = 4.
  - Required: those 3 beats are dropped, first chk_vld carries lane0 = 0, beat_cnt = 4, pass = 1.
- Corrupted beat: beat 5 of 8 has one bit flipped.
  - Required: err_lat = 1, suc_lat = 7, pass = 0.
  - With ADC_CHK_STOP_ON_ERR_EN: beat_cnt = 5 and the session ends early.
- Unbounded mode: cfg_len = 0, 100 beats, then stop.
  - Required: beat_cnt = 100, DRAIN then DONE, pass = 1.
  - A start issued while busy is ignored.
- Timeout: SYNC_TMO = 16, adc_vld held 0 after CLR.
  - Required: tmo = 1 after 16 idle cycles, pass = 0, beat_cnt = 0.
  - Assert rst mid-RUN: all outputs return to 0 and state is IDLE.

Source files
------------

// File: rtl/ddr_20g_adc_chk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_20g_adc_chk_ctrl
//  Description : Session controller for the 20G ADC pattern checker.
//                Clears the checker, aligns to the pattern origin
//                (lane0 == 0), gates a window of cfg_len beats into the
//                checker, drains, then latches the result counters and a
//                pass flag.
//  Option      : ADC_CHK_STOP_ON_ERR_EN - end RUN as soon as the checker
//                reports a non-zero error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_20g_adc_chk_ctrl #(
   parameter int DATA_WD   = 256,
   parameter int CLR_CYC   = 4,
   parameter int DRAIN_CYC = 4,
   parameter int SYNC_TMO  = 65535
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [31:0]        i_cfg_len,
   input  logic               i_adc_vld,
   input  logic [DATA_WD-1:0] i_adc_data,
   output logic               o_chk_rst,
   output logic               o_chk_vld,
   output logic [DATA_WD-1:0] o_chk_data,
   input  logic [31:0]        i_suc_cnt,
   input  logic [31:0]        i_err_cnt,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic               o_tmo,
   output logic [31:0]        o_beat_cnt,
   output logic [31:0]        o_suc_lat,
   output logic [31:0]        o_err_lat
);

   localparam int c_tmo_w = $clog2(SYNC_TMO + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_SYNC  = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_cyc_cnt;
   logic [c_tmo_w-1:0]   r_idle_cnt;
   logic [31:0]          r_len;
   logic [31:0]          r_beat_cnt;
   logic [31:0]          r_suc_lat;
   logic [31:0]          r_err_lat;
   logic                 r_pass;
   logic                 r_tmo;
   logic                 r_done;
   logic                 r_chk_vld;
   logic [DATA_WD-1:0]   r_chk_data;

   logic                 w_gate;
   logic                 w_len_hit;
   logic                 w_tmo_hit;
   logic                 w_err_stop;
   logic                 w_hunting;

   // Beat-count bookkeeping shared by SYNC and RUN: the beat that brings
   // the count up to the window length is the last one forwarded.
   assign w_len_hit = (r_len != 32'd0) && ((r_beat_cnt + 32'd1) == r_len);
   assign w_hunting = (r_state == S_SYNC) || (r_state == S_RUN);
   assign w_tmo_hit = w_hunting && !i_adc_vld &&
                      (r_idle_cnt == c_tmo_w'(SYNC_TMO - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode and beat gating decision
   always_comb begin
      w_next     = r_state;
      w_gate     = 1'b0;
      w_err_stop = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) w_next = S_CLR;
         end
         S_CLR: begin
            if (r_cyc_cnt == 4'(CLR_CYC - 1)) w_next = S_SYNC;
         end
         S_SYNC: begin
            w_gate = i_adc_vld && (i_adc_data[15:0] == 16'h0);
            if (w_gate)         w_next = w_len_hit ? S_DRAIN : S_RUN;
            else if (w_tmo_hit) w_next = S_DRAIN;
         end
         S_RUN: begin
`ifdef ADC_CHK_STOP_ON_ERR_EN
            w_err_stop = (i_err_cnt != 32'd0);
`else
            w_err_stop = 1'b0;
`endif
            w_gate = i_adc_vld && !w_err_stop;
            if (w_err_stop || i_stop || (w_gate && w_len_hit) || w_tmo_hit)
               w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_cyc_cnt == 4'(DRAIN_CYC - 1)) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Dwell counter for CLR/DRAIN and idle counter for the timeout, both
   // restarted on every state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cyc_cnt  <= 4'd0;
         r_idle_cnt <= '0;
      end else begin
         if (w_next != r_state)
            r_cyc_cnt <= 4'd0;
         else if ((r_state == S_CLR) || (r_state == S_DRAIN))
            r_cyc_cnt <= r_cyc_cnt + 4'd1;

         if ((w_next != r_state) || i_adc_vld || !w_hunting)
            r_idle_cnt <= '0;
         else
            r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   // Datapath, session bookkeeping and result latching
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chk_data <= '0;
         r_chk_vld  <= 1'b0;
         r_len      <= 32'd0;
         r_beat_cnt <= 32'd0;
         r_suc_lat  <= 32'd0;
         r_err_lat  <= 32'd0;
         r_pass     <= 1'b0;
         r_tmo      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_chk_data <= i_adc_data;
         r_chk_vld  <= w_gate;
         r_done     <= 1'b0;
         if (((r_state == S_IDLE) || (r_state == S_DONE)) && i_start) begin
            r_len      <= i_cfg_len;
            r_beat_cnt <= 32'd0;
            r_suc_lat  <= 32'd0;
            r_err_lat  <= 32'd0;
            r_pass     <= 1'b0;
            r_tmo      <= 1'b0;
         end
         // Saturate rather than wrap in unbounded mode
         if (w_gate && (r_beat_cnt != 32'hFFFF_FFFF))
            r_beat_cnt <= r_beat_cnt + 32'd1;
         if (w_tmo_hit)
            r_tmo <= 1'b1;
         if ((r_state == S_DRAIN) && (w_next == S_DONE)) begin
            r_suc_lat <= i_suc_cnt;
            r_err_lat <= i_err_cnt;
            r_pass    <= (i_err_cnt == 32'd0) && (i_suc_cnt == r_beat_cnt) &&
                         (r_beat_cnt != 32'd0) && !r_tmo;
            r_done    <= 1'b1;
         end
      end
   end

   assign o_chk_rst  = (r_state == S_CLR);
   assign o_busy     = (r_state == S_CLR) || (r_state == S_SYNC) ||
                       (r_state == S_RUN) || (r_state == S_DRAIN);
   assign o_chk_vld  = r_chk_vld;
   assign o_chk_data = r_chk_data;
   assign o_done     = r_done;
   assign o_pass     = r_pass;
   assign o_tmo      = r_tmo;
   assign o_beat_cnt = r_beat_cnt;
   assign o_suc_lat  = r_suc_lat;
   assign o_err_lat  = r_err_lat;

endmodule
`default_nettype wire

// File: tb/tb_ddr_20g_adc_chk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_20g_adc_chk_ctrl
//  Description : Scoreboard bench for ddr_20g_adc_chk_ctrl with a small
//                behavioural pattern checker on the downstream side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_20g_adc_chk_ctrl;

   localparam int DATA_WD   = 256;
   localparam int CLR_CYC   = 4;
   localparam int DRAIN_CYC = 4;
   localparam int SYNC_TMO  = 16;

   typedef struct {
      logic [31:0] beat;
      logic [31:0] suc;
      logic [31:0] err;
      logic        pass;
      logic        tmo;
   } res_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic [31:0]        cfg_len = 32'd0;
   logic               adc_vld = 1'b0;
   logic [DATA_WD-1:0] adc_data = '0;
   logic               chk_rst, chk_vld, busy, done, pass, tmo;
   logic [DATA_WD-1:0] chk_data;
   logic [31:0]        suc_cnt = 32'd0;
   logic [31:0]        err_cnt = 32'd0;
   logic [31:0]        beat_cnt, suc_lat, err_lat;
   int                 seq = 0;

   int                 n_chk = 0;
   int                 n_err = 0;
   int                 rst_hi = 0;
   logic [DATA_WD-1:0] beat_q[$];
   res_t               res_q[$];

   ddr_20g_adc_chk_ctrl #(
      .DATA_WD(DATA_WD), .CLR_CYC(CLR_CYC),
      .DRAIN_CYC(DRAIN_CYC), .SYNC_TMO(SYNC_TMO)
   ) u_dut (
      .clk(clk), .rst(rst), .i_start(start), .i_stop(stop),
      .i_cfg_len(cfg_len), .i_adc_vld(adc_vld), .i_adc_data(adc_data),
      .o_chk_rst(chk_rst), .o_chk_vld(chk_vld), .o_chk_data(chk_data),
      .i_suc_cnt(suc_cnt), .i_err_cnt(err_cnt), .o_busy(busy),
      .o_done(done), .o_pass(pass), .o_tmo(tmo), .o_beat_cnt(beat_cnt),
      .o_suc_lat(suc_lat), .o_err_lat(err_lat)
   );

   always #5 clk = ~clk;

   // Pattern beat k: lane j carries 16*k + j
   function automatic logic [DATA_WD-1:0] pat(input int k);
      logic [DATA_WD-1:0] p;
      for (int j = 0; j < 16; j++) p[j*16 +: 16] = 16'(k * 16 + j);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [DATA_WD-1:0] act,
                      input logic [DATA_WD-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Behavioural downstream checker: counts beats matching the pattern
   always @(posedge clk) begin
      if (chk_rst) begin
         suc_cnt <= 32'd0;
         err_cnt <= 32'd0;
         seq     <= 0;
      end else if (chk_vld) begin
         if (chk_data == pat(seq)) suc_cnt <= suc_cnt + 32'd1;
         else                      err_cnt <= err_cnt + 32'd1;
         seq <= seq + 1;
      end
   end

   // Output monitor: clear width, forwarded beats and session results
   always @(negedge clk) begin
      if (chk_rst) rst_hi++;
      else if (rst_hi != 0) begin
         chk("chk_rst_cyc", rst_hi, CLR_CYC);
         rst_hi = 0;
      end
      if (chk_vld) begin
         if (beat_q.size() == 0) chk("unexp_vld", chk_vld, 0);
         else                    chk("chk_data", chk_data, beat_q.pop_front());
      end
      if (done) begin
         if (res_q.size() == 0) chk("unexp_done", done, 0);
         else begin
            res_t r;
            r = res_q.pop_front();
            chk("beat_cnt", beat_cnt, r.beat);
            chk("suc_lat", suc_lat, r.suc);
            chk("err_lat", err_lat, r.err);
            chk("pass", pass, r.pass);
            chk("tmo", tmo, r.tmo);
         end
      end
   end

   task automatic exp_res(input int b, input int s, input int e,
                          input bit p, input bit t);
      res_t r;
      r.beat = b; r.suc = s; r.err = e; r.pass = p; r.tmo = t;
      res_q.push_back(r);
   endtask

   task automatic do_start(input int len);
      cfg_len = len;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Returns on the first cycle after the checker clear has ended
   task automatic wait_sync();
      int n = 0;
      while (!chk_rst && n < 50) begin @(negedge clk); n++; end
      while (chk_rst && n < 50)  begin @(negedge clk); n++; end
      if (n >= 50) chk("sync_wait", chk_rst, 0);
   endtask

   task automatic drv(input logic [DATA_WD-1:0] d, input bit fwd);
      adc_vld  = 1'b1;
      adc_data = d;
      if (fwd) beat_q.push_back(d);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      adc_vld  = 1'b0;
      adc_data = '0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      adc_vld = 1'b0;
      while (!done && n < bound) begin @(negedge clk); n++; end
      if (!done) chk("done_wait", done, 1);
      else begin
         @(negedge clk);
         chk("done_pulse", done, 0);
         chk("busy_after", busy, 0);
         chk("beat_q_left", beat_q.size(), 0);
      end
   endtask

   initial begin
      logic [DATA_WD-1:0] bad;
      repeat (3) @(negedge clk);
      chk("reset_outs", {chk_rst, chk_vld, busy, done, pass, tmo, beat_cnt,
                         suc_lat, err_lat, chk_data[63:0]}, '0);
      rst = 1'b0;
      @(negedge clk);

      // Clean 8-beat session
      exp_res(8, 8, 0, 1, 0);
      do_start(8);
      chk("busy_clr", busy, 1);
      wait_sync();
      for (int k = 0; k < 8; k++) drv(pat(k), 1);
      wait_done(100);

      // Alignment: three non-origin beats are dropped
      exp_res(4, 4, 0, 1, 0);
      do_start(4);
      wait_sync();
      for (int k = 0; k < 3; k++) drv(pat(1), 0);
      for (int k = 0; k < 4; k++) drv(pat(k), 1);
      wait_done(100);

      // Corrupted fifth beat, short gap so an error stop can take effect
      bad = pat(4);
      bad[100] = ~bad[100];
`ifdef ADC_CHK_STOP_ON_ERR_EN
      exp_res(5, 4, 1, 0, 0);
`else
      exp_res(8, 7, 1, 0, 0);
`endif
      do_start(8);
      wait_sync();
      for (int k = 0; k < 4; k++) drv(pat(k), 1);
      drv(bad, 1);
      idle(3);
`ifdef ADC_CHK_STOP_ON_ERR_EN
      for (int k = 5; k < 8; k++) drv(pat(k), 0);
`else
      for (int k = 5; k < 8; k++) drv(pat(k), 1);
`endif
      wait_done(100);

      // Unbounded window ended by stop; start while busy is ignored
      exp_res(100, 100, 0, 1, 0);
      do_start(0);
      wait_sync();
      for (int k = 0; k < 100; k++) begin
         if (k == 50) begin
            start = 1'b1;
            chk("busy_run", busy, 1);
         end
         drv(pat(k), 1);
         start = 1'b0;
      end
      idle(1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_done(100);

      // Timeout: no beats after the clear
      exp_res(0, 0, 0, 0, 1);
      do_start(8);
      wait_sync();
      wait_done(100);

      // Asynchronous reset in the middle of RUN
      do_start(0);
      wait_sync();
      for (int k = 0; k < 10; k++) drv(pat(k), 1);
      idle(1);
      chk("beat_pre_rst", beat_cnt, 10);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_beat", beat_cnt, 0);
      chk("rst_outs", {chk_rst, chk_vld, done, pass, tmo, suc_lat, err_lat,
                       chk_data}, '0);
      res_q.delete();
      rst = 1'b0;
      @(negedge clk);

      // Fresh session after reset re-clears the checker
      exp_res(4, 4, 0, 1, 0);
      do_start(4);
      wait_sync();
      for (int k = 0; k < 4; k++) drv(pat(k), 1);
      wait_done(100);

      chk("res_q_left", res_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
